// File: rtl/gamepad_source_arbiter.sv
// gamepad_source_arbiter: shares one 12-bit pad between the PCB, USB and BT sources; handoff needs an idle owner plus a confirmed challenger
// Ports: clk, reset (sync, active-high); pcb_btn; usb_btn/usb_connected; bt_btn/bt_connected; lock;
//        pad_btn (owner buttons, registered); active_source (owner code); source_changed (1-cycle pulse per change)
module gamepad_source_arbiter #(
  parameter int DEFAULT_SOURCE = 0,
  parameter int IDLE_CYCLES = 65536,
  parameter int CONFIRM_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] pcb_btn,
  input  logic [11:0] usb_btn,
  input  logic        usb_connected,
  input  logic [11:0] bt_btn,
  input  logic        bt_connected,
  input  logic        lock,
  output logic [11:0] pad_btn,
  output logic [1:0]  active_source,
  output logic        source_changed
);
  localparam int IW = $clog2(IDLE_CYCLES + 1);
  localparam int CW = $clog2(CONFIRM_CYCLES);
  localparam logic [1:0] NONE = 2'd3;
  typedef enum logic {OWN, CONFIRM} state_e;
  state_e state_q, state_d;
  logic [1:0] owner_q, owner_d, cand_q, cand_d, cand;
  logic [IW-1:0] idle_q, idle_d;
  logic [CW-1:0] conf_q, conf_d;
  logic [11:0] pad_q, pad_d;
  logic chg_q, chg_d;
  logic [11:0] btn [4];
  logic [3:0] conn;
  logic owner_idle, fallback, cond;
  assign btn[0] = pcb_btn;
  assign btn[1] = usb_btn;
  assign btn[2] = bt_btn;
  assign btn[3] = 12'h000;
  // code 3 is never connected, so an illegal default falls back to PCB
  assign conn = {1'b0, bt_connected, usb_connected, 1'b1};
  assign owner_idle = idle_q == IW'(IDLE_CYCLES);
  assign fallback = !conn[owner_q];
  assign cand = (owner_q != 2'd1 && usb_connected && |usb_btn) ? 2'd1 :
                (owner_q != 2'd2 && bt_connected && |bt_btn) ? 2'd2 :
                (owner_q != 2'd0 && |pcb_btn) ? 2'd0 : NONE;
  assign cond = !lock && owner_idle && cand == cand_q;
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cand_d = cand_q;
    conf_d = conf_q;
    chg_d = 1'b0;
    idle_d = |btn[owner_q] ? '0 : owner_idle ? idle_q : idle_q + 1'b1;
    if (fallback) begin
      owner_d = 2'd0;
      chg_d = 1'b1;
      state_d = OWN;
      idle_d = '0;
      conf_d = '0;
    end else if (state_q == OWN) begin
      if (!lock && owner_idle && cand != NONE) begin
        state_d = CONFIRM;
        cand_d = cand;
        conf_d = CW'(1);
      end
    end else if (cond && conf_q == CW'(CONFIRM_CYCLES - 1)) begin
      owner_d = cand_q;
      chg_d = 1'b1;
      idle_d = '0;
      conf_d = '0;
      state_d = OWN;
    end else if (cond) begin
      conf_d = conf_q + 1'b1;
    end else begin
      state_d = OWN;
      conf_d = '0;
    end
    pad_d = conn[owner_d] ? btn[owner_d] : 12'h000;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= OWN;
      owner_q <= 2'(DEFAULT_SOURCE);
      cand_q <= NONE;
      conf_q <= '0;
      idle_q <= '0;
      pad_q <= '0;
      chg_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cand_q <= cand_d;
      conf_q <= conf_d;
      idle_q <= idle_d;
      pad_q <= pad_d;
      chg_q <= chg_d;
    end
  end
  assign pad_btn = pad_q;
  assign active_source = owner_q;
  assign source_changed = chg_q;
endmodule

// File: doc/gamepad_source_arbiter.md
Name: gamepad_source_arbiter

Overview:
Runtime arbiter that shares the single 12-bit pad_btn consumer between three gamepad sources: PCB buttons, USB gamepad and ESP32/Bluetooth gamepad. One source owns the pad at a time. Ownership hands off only when the owner has been idle and a challenger has pressed consistently, which prevents two players from fighting over the pad. It sits between the per-source readers (inputs already synchronised to clk) and the CPU-visible gamepad register.

Parameters:
DEFAULT_SOURCE, 0, owner after reset (0=PCB, 1=USB, 2=BT; 3 illegal)
IDLE_CYCLES, 65536, consecutive all-released owner cycles required before a handoff may start (>=1)
CONFIRM_CYCLES, 4, consecutive cycles a challenger must hold a nonzero press to win ownership (>=2)

Ports:
clk  input  1  system clock
reset  input  1  synchronous active-high reset
pcb_btn  input  12  PCB button state, active-high; PCB is always connected
usb_btn  input  12  USB gamepad state, synchronised to clk
usb_connected  input  1  USB source present
bt_btn  input  12  Bluetooth gamepad state, synchronised to clk
bt_connected  input  1  Bluetooth source present
lock  input  1  when high, inhibits all voluntary handoffs
pad_btn  output  12  buttons of the current owner, registered
active_source  output  2  current owner code
source_changed  output  1  one-cycle pulse on every ownership change

Behaviour:
- Reset (sync): owner/active_source=DEFAULT_SOURCE, pad_btn=0, source_changed=0, idle_cnt=0, conf_cnt=0, state=OWN.
- Notation: btn(s) and conn(s) select per-source inputs. conn(0)=1 always.
- pad_btn: registered every cycle from next_owner, as conn(next_owner) ? btn(next_owner) : 0. This gives 1-cycle latency from input to output. pad_btn and active_source always update on the same edge and are always consistent.
- idle_cnt: increments when btn(owner)==0, saturating at IDLE_CYCLES. Cleared when btn(owner)!=0 and on any ownership change. owner_idle = (idle_cnt==IDLE_CYCLES).
- candidate: highest-priority source other than the owner with conn=1 and btn!=0. Priority is USB > BT > PCB. "None" when no source qualifies.
- State OWN:
  - If !lock && owner_idle && candidate!=none: go to CONFIRM, cand_reg=candidate, conf_cnt=1.
- State CONFIRM, per cycle, with cond = !lock && owner_idle && candidate==cand_reg:
  - cond true and conf_cnt==CONFIRM_CYCLES-1: switch. owner<=cand_reg, source_changed<=1, idle_cnt<=0, conf_cnt<=0, state OWN.
  - cond true otherwise: conf_cnt++.
  - cond false: state OWN, conf_cnt<=0. The challenger must restart from scratch.
- Net effect: a switch occurs on the edge ending the CONFIRM_CYCLES-th consecutive qualifying cycle.
- Disconnect fallback: if owner!=0 and conn(owner)==0, the next edge sets owner<=0 (PCB), source_changed<=1, state OWN, idle_cnt<=0, conf_cnt<=0.
  - Overrides any pending CONFIRM.
  - Ignores lock.
  - Applies immediately after reset if DEFAULT_SOURCE is unconnected.
- source_changed: high exactly one cycle per change. Deasserts the next cycle unless another change occurs.
- Owner pressing (btn(owner)!=0) clears idle_cnt. This aborts CONFIRM on the next cycle.
- lock asserted mid-CONFIRM aborts it. Deasserting lock does not resume the count; a new full CONFIRM is required. idle_cnt keeps counting while locked.
- A challenger's held press passes to pad_btn on the switch edge. No masking is applied.

Test Plan:
Params for all scenarios: IDLE_CYCLES=8, CONFIRM_CYCLES=3, DEFAULT_SOURCE=0.
1. Reset 2 cycles, pcb_btn=12'h005 -> active_source=0, source_changed=0; pad_btn=12'h005 on the first edge after reset deasserts.
2. pcb_btn=0 for >=8 cycles, usb_connected=1, usb_btn=12'h010 held -> CONFIRM entered, switch on 3rd qualifying edge. Then active_source=1, pad_btn=12'h010 same edge, source_changed high exactly 1 cycle.
3. pcb_btn=12'h001 held, usb_btn=12'h010 held for 100 cycles -> no switch, active_source=0.
   Separately: PCB idle, usb_btn pulses 2 cycles then 0 -> no switch, conf_cnt returns 0.
4. PCB idle, usb_btn=12'h002 and bt_btn=12'h004 both held, both connected -> USB wins (active_source=1).
   Then usb_btn=12'h002 still held, bt_btn pressed -> no switch.
5. Owner USB, usb_connected falls -> next edge active_source=0, pad_btn=pcb_btn, 1-cycle source_changed; same result with lock=1 or mid-CONFIRM.
6. lock=1, PCB idle, usb_btn held 50 cycles -> no switch. Drop lock -> switch 3 edges later.
   Separately: reset asserted mid-CONFIRM -> outputs return to reset values, no pulse.
